// File: rtl/cdf_pipeline.sv
// cdf_pipeline: streams 256 histogram bins out of a scratchpad bank, builds
// the running CDF and an 8-bit equalisation LUT entry per bin, writes each
// result to the m3 table and clears the bin behind itself in the m2 bank.
//
// Timing of bin k (cycle t = m2ReadAddr shows bin k):
//   t   : address issued              (idx_q / off_q)
//   t+1 : bin word on m2ReadVal       (s0 tag stage)
//   t+2 : decoded count registered    (s1 stage), cdf/lut computed
//   t+3 : m3 write + m2 clear visible (wr stage)
//
// Handshake: start is a level request; it is sampled only in IDLE and is
// ignored during READ/DRAIN. done stays high in DONE until start is seen
// low, after which the block returns to IDLE on the next edge.
module cdf_pipeline #(
  parameter int LOG2_PIXELS = 6
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         start,
  input  logic         inputBaseOffset,
  input  logic [127:0] m2ReadVal,
  output logic [15:0]  m2ReadAddr,
  output logic         m2WE,
  output logic [15:0]  m2WriteAddr,
  output logic [127:0] m2WriteVal,
  output logic         m3WE,
  output logic [15:0]  m3WriteAddr,
  output logic [127:0] m3WriteVal,
  output logic         done,
  output logic [1:0]   dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic        off_q, off_d;
  logic [1:0]  drain_q, drain_d;
  logic        cdf_clr;

  // Pipeline registers
  logic        s0_v_q;
  logic [7:0]  s0_idx_q;
  logic        s1_v_q;
  logic [7:0]  s1_idx_q;
  logic [15:0] s1_cnt_q;
  logic        wr_v_q;
  logic [7:0]  wr_idx_q;
  logic [7:0]  lut_q;
  logic [23:0] cdf_q;

  // Datapath helpers
  logic [15:0] cnt_dec;
  logic [23:0] cdf_sum;
  logic [31:0] prod;
  logic [31:0] scaled;
  logic [7:0]  lut_d;
  logic        unused_read_bits;

  // State, bin index and bank select registers
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 8'd0;
      off_q   <= 1'b0;
      drain_q <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      drain_q <= drain_d;
    end
  end

  // Next-state logic; idx_q freezes at 255 so the read address holds after READ
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    off_d   = off_q;
    drain_d = drain_q;
    cdf_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          idx_d   = 8'd0;
          off_d   = inputBaseOffset;
          cdf_clr = 1'b1;
        end
      end
      S_READ: begin
        if (idx_q == 8'd255) begin
          state_d = S_DRAIN;
          drain_d = 2'd0;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end
      S_DRAIN: begin
        if (drain_q == 2'd2) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      S_DONE: begin
        if (!start) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bin decode, running sum and saturating LUT scale
  always_comb begin
    cnt_dec = (m2ReadVal[31:16] == 16'hAAAA) ? m2ReadVal[15:0] : 16'd0;
    cdf_sum = cdf_q + {8'd0, s1_cnt_q};
    prod    = {8'd0, cdf_sum} * 32'd255;
    scaled  = prod >> LOG2_PIXELS;
    lut_d   = (scaled > 32'd255) ? 8'hFF : scaled[7:0];
  end

  assign unused_read_bits = ^m2ReadVal[127:32];

  // Three-stage pipeline from read address to table/clear write
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s0_v_q   <= 1'b0;
      s0_idx_q <= 8'd0;
      s1_v_q   <= 1'b0;
      s1_idx_q <= 8'd0;
      s1_cnt_q <= 16'd0;
      wr_v_q   <= 1'b0;
      wr_idx_q <= 8'd0;
      lut_q    <= 8'd0;
      cdf_q    <= 24'd0;
    end else begin
      s0_v_q   <= (state_q == S_READ);
      s0_idx_q <= idx_q;
      s1_v_q   <= s0_v_q;
      s1_idx_q <= s0_idx_q;
      s1_cnt_q <= cnt_dec;
      wr_v_q   <= s1_v_q;
      if (cdf_clr) begin
        cdf_q <= 24'd0;
      end else if (s1_v_q) begin
        cdf_q    <= cdf_sum;
        lut_q    <= lut_d;
        wr_idx_q <= s1_idx_q;
      end
    end
  end

  assign m2ReadAddr  = {7'd0, off_q, idx_q};
  assign m2WE        = wr_v_q;
  assign m2WriteAddr = {7'd0, off_q, wr_idx_q};
  assign m2WriteVal  = 128'd0;
  assign m3WE        = wr_v_q;
  assign m3WriteAddr = {8'd0, wr_idx_q};
  assign m3WriteVal  = {88'd0, lut_q, 8'd0, cdf_q};
  assign done        = (state_q == S_DONE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cdf_pipeline.sv
// Bench for cdf_pipeline: scratchpad model, directed runs, expected table
// entries queued per run and popped as the DUT writes them.
module tb_cdf_pipeline;

  localparam int LOG2_PIXELS = 6;

  logic         clock = 1'b0;
  logic         rst_n;
  logic         start;
  logic         inputBaseOffset;
  logic [127:0] m2ReadVal;
  logic [15:0]  m2ReadAddr;
  logic         m2WE;
  logic [15:0]  m2WriteAddr;
  logic [127:0] m2WriteVal;
  logic         m3WE;
  logic [15:0]  m3WriteAddr;
  logic [127:0] m3WriteVal;
  logic         done;
  logic [1:0]   dbg_state;

  // Clock
  always #5 clock = ~clock;

  cdf_pipeline #(.LOG2_PIXELS(LOG2_PIXELS)) dut (
    .clock          (clock),
    .rst_n          (rst_n),
    .start          (start),
    .inputBaseOffset(inputBaseOffset),
    .m2ReadVal      (m2ReadVal),
    .m2ReadAddr     (m2ReadAddr),
    .m2WE           (m2WE),
    .m2WriteAddr    (m2WriteAddr),
    .m2WriteVal     (m2WriteVal),
    .m3WE           (m3WE),
    .m3WriteAddr    (m3WriteAddr),
    .m3WriteVal     (m3WriteVal),
    .done           (done),
    .dbg_state_o    (dbg_state)
  );

  // Scratchpad model: two banks of 256 words, one-cycle read latency
  logic [127:0] mem [0:511];
  logic [127:0] frame [0:255];
  logic         fill_req;
  logic         fill_bank;

  always @(posedge clock) begin
    if (fill_req) begin
      for (int k = 0; k < 256; k++) mem[{fill_bank, 8'(k)}] <= frame[k];
    end else if (m2WE) begin
      mem[m2WriteAddr[8:0]] <= m2WriteVal;
    end
    m2ReadVal <= mem[m2ReadAddr[8:0]];
  end

  // Scoreboard: {bin[7:0], lut[7:0], cdf[23:0]}
  logic [39:0] exp_q[$];
  logic        exp_off;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_wr_cyc = 0;
  int          writes = 0;
  int          w0;
  logic [15:0] hist [0:2];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_pattern(input int kind);
    logic [127:0] w;
    for (int k = 0; k < 256; k++) begin
      w = 128'd0;
      case (kind)
        0: if (k < 64) w = {96'd0, 16'hAAAA, 16'h0001};
        1: if (k == 200) w = {96'd0, 16'hAAAA, 16'h0040};
        default: begin
          w[127:32] = {$urandom, $urandom, $urandom};
          case ($urandom_range(0, 3))
            0: w[31:0] = {16'hAAAA, 16'($urandom_range(0, 3))};
            1: w[31:0] = {16'hAAAA, 16'($urandom_range(0, 65535))};
            2: w[31:0] = {16'h1234, 16'($urandom_range(0, 65535))};
            default: w = 128'd0;
          endcase
          if (k == 5) w = {96'd0, 32'h1234_0010};
        end
      endcase
      frame[k] = w;
    end
  endtask

  task automatic fill(input logic bank);
    fill_bank = bank;
    fill_req  = 1'b1;
    @(negedge clock);
    fill_req  = 1'b0;
    #1;
  endtask

  task automatic build_expected(input logic bank);
    int unsigned cdf;
    int unsigned p;
    int unsigned l;
    logic [127:0] w;
    logic [15:0]  cnt;
    cdf = 0;
    exp_off = bank;
    for (int k = 0; k < 256; k++) begin
      w   = frame[k];
      cnt = (w[31:16] == 16'hAAAA) ? w[15:0] : 16'd0;
      cdf = cdf + cnt;
      p   = cdf * 255;
      l   = p >> LOG2_PIXELS;
      if (l > 255) l = 255;
      exp_q.push_back({8'(k), 8'(l), 24'(cdf)});
    end
  endtask

  // One clock, sampled 1 time unit after the falling edge
  task automatic step();
    logic [39:0] e;
    @(negedge clock);
    #1;
    cyc++;
    chk("we_pair", {127'd0, m2WE}, {127'd0, m3WE});
    if (m3WE) begin
      writes++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {112'd0, m3WriteAddr}, 128'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("m3_addr", {112'd0, m3WriteAddr}, {120'd0, e[39:32]});
        chk("m3_val", m3WriteVal, {88'd0, e[31:24], 8'd0, e[23:0]});
        chk("m2_addr", {112'd0, m2WriteAddr}, {112'd0, 7'd0, exp_off, e[39:32]});
        chk("m2_val", m2WriteVal, 128'd0);
        chk("lat3", {112'd0, hist[2]}, {112'd0, 7'd0, exp_off, e[39:32]});
        if (e[39:32] != 8'd0) chk("no_gap", 128'(cyc - last_wr_cyc), 128'd1);
      end
      last_wr_cyc = cyc;
    end
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = m2ReadAddr;
  endtask

  task automatic wait_done(input int wstart);
    int n;
    n = 0;
    while (!done && n < 400) begin
      step();
      n++;
    end
    chk("done_timeout", {127'd0, done}, 128'd1);
    chk("sb_empty", 128'(exp_q.size()), 128'd0);
    chk("write_count", 128'(writes - wstart), 128'd256);
    chk("done_gap", 128'(cyc - last_wr_cyc), 128'd1);
  endtask

  task automatic check_bank_clear(input logic bank);
    int bad;
    bad = 0;
    for (int k = 0; k < 256; k++) if (mem[{bank, 8'(k)}] !== 128'd0) bad++;
    chk("bank_clear", 128'(bad), 128'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_done"}, {127'd0, done}, 128'd0);
    chk({tag, "_m2we"}, {127'd0, m2WE}, 128'd0);
    chk({tag, "_m3we"}, {127'd0, m3WE}, 128'd0);
    chk({tag, "_rdaddr"}, {112'd0, m2ReadAddr}, 128'd0);
    chk({tag, "_m2addr"}, {112'd0, m2WriteAddr}, 128'd0);
    chk({tag, "_m2val"}, m2WriteVal, 128'd0);
    chk({tag, "_m3addr"}, {112'd0, m3WriteAddr}, 128'd0);
    chk({tag, "_m3val"}, m3WriteVal, 128'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    inputBaseOffset = 1'b0;
    fill_req = 1'b0;
    fill_bank = 1'b0;
    for (int i = 0; i < 3; i++) hist[i] = 16'd0;

    // Run 1: uniform frame, start held through reset, accepted on first edge
    set_pattern(0);
    fill(1'b0);
    start = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    check_outputs_zero("reset");
    build_expected(1'b0);
    w0 = writes;
    rst_n = 1'b1;
    step();
    step();
    chk("accept_first_edge", {112'd0, m2ReadAddr}, 128'd1);
    wait_done(w0);
    check_bank_clear(1'b0);

    // Handshake: done holds while start stays high, no writes
    w0 = writes;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("done_held", {127'd0, done}, 128'd1);
    end
    chk("no_write_in_done", 128'(writes - w0), 128'd0);
    start = 1'b0;
    step();
    chk("done_drop", {127'd0, done}, 128'd0);
    step();

    // Run 2: single value in bank 1; offset change and start drop mid-run ignored
    set_pattern(1);
    fill(1'b1);
    build_expected(1'b1);
    inputBaseOffset = 1'b1;
    start = 1'b1;
    w0 = writes;
    step();
    inputBaseOffset = 1'b0;
    repeat (10) step();
    start = 1'b0;
    wait_done(w0);
    step();
    check_bank_clear(1'b1);

    // Run 3: random tagged/untagged frame with junk at bin 5
    set_pattern(2);
    fill(1'b0);
    build_expected(1'b0);
    start = 1'b1;
    w0 = writes;
    wait_done(w0);
    start = 1'b0;
    step();
    check_bank_clear(1'b0);

    // Run 4: reset while bin 100 is being written
    set_pattern(0);
    fill(1'b0);
    build_expected(1'b0);
    start = 1'b1;
    n = 0;
    step();
    while (!(m3WE && m3WriteAddr == 16'd100) && n < 300) begin
      step();
      n++;
    end
    chk("found_bin100", {112'd0, m3WriteAddr}, 128'd100);
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    check_outputs_zero("abort");
    exp_q.delete();
    repeat (5) step();
    chk("bin101_intact", mem[101], frame[101]);
    chk("bin100_cleared", mem[100], 128'd0);
    rst_n = 1'b1;
    step();

    // Restart after abort: full table from bin 0
    fill(1'b0);
    build_expected(1'b0);
    start = 1'b1;
    w0 = writes;
    wait_done(w0);
    start = 1'b0;
    step();
    check_bank_clear(1'b0);

    // Run 5: identical rerun of the uniform frame
    fill(1'b0);
    build_expected(1'b0);
    start = 1'b1;
    w0 = writes;
    wait_done(w0);
    start = 1'b0;
    step();
    chk("idle_after_run", {127'd0, done}, 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
